tiny_dnn_mac_array: RTL
=======================

// Module: tiny_dnn_mac_array
// PURPOSE
//  Multi-lane bfloat16 dot-product engine: LANES neurons share one broadcast feature stream.
//  Each lane owns a private weight RAM, a bf16 x bf16 fixed-point accumulator and an fp32
//  normaliser. A sequencer FSM replaces per-element exec/bias strobes with a start/len command
//  and valid/ready streams. Sits between the feature loader and the activation/output buffer.
// PARAMETERS
//  LANES   4     number of parallel neurons (output channels)
//  F_SIZE  1024  weight words per lane; address F_SIZE-1 holds the lane bias
//  AW      $clog2(F_SIZE)  address / length width (derived, do not override)
// PORTS
//  clk       in   1           single clock, rising edge
//  reset     in   1           asynchronous, active-high; clears FSM, accumulators, outputs
//  wr_en     in   1           weight write strobe (honoured in IDLE only)
//  wr_lane   in   $clog2(LANES) target lane
//  wr_addr   in   AW          weight address; F_SIZE-1 = bias
//  wr_data   in   16          bf16 weight
//  start     in   1           command strobe (honoured in IDLE only)
//  len       in   AW          element count, sampled with start; range 0..F_SIZE-1
//  use_bias  in   1           add bias term, sampled with start
//  busy      out  1           high in any state other than IDLE
//  d_valid   in   1           feature element valid
//  d_ready   out  1           high only in RUN while elements remain
//  d_data    in   16          bf16 feature, broadcast to all lanes
//  out_valid out  1           result vector valid
//  out_ready in   1           consumer accepts result vector
//  out_data  out  32*LANES    fp32 per lane; lane i at [32*i+31:32*i]
// BEHAVIOUR
//  Reset: state=IDLE; busy, d_ready, out_valid=0; out_data=0; each lane acc sign/exp/mant=0.
//  Weight RAM is not reset.
//  FSM: IDLE -start-> RUN (acc cleared, cnt=0). In RUN, cnt increments on d_valid&d_ready.
//  When cnt==len: go to BIAS if use_bias, else DRAIN. BIAS lasts 1 cycle, d=0x3F80 with W[F_SIZE-1].
//  DRAIN lasts 2 cycles (RAM-read reg + FMA reg). NORM lasts 1 cycle (registered normalise).
//  OUT holds out_valid/out_data stable until out_ready, then IDLE.
//  len=0: RUN falls straight through; d_ready never asserts.
//  Latency: out_valid rises 4 cycles after the last data handshake (5 with bias).
//  Element k multiplies W[lane][k] with the k-th accepted d_data.
//  FMA step: frac = {1,w[6:0]}*{1,d[6:0]} (16b); expm = w.exp + d.exp; expd = expm - acc_exp + 16.
//    Signs differ -> accumulator negated before alignment.
//    align = ({acc,16'b0} >>> expd), or 0 if expd>=64.
//    If expd<0, or align[48:30] is not all-0/all-1, the step is discarded (acc unchanged).
//    Otherwise: acc_sign = w.s^d.s, acc_exp = expm, acc = frac + align (32b signed).
//    bf16 exponent 0 is not special: hidden bit always 1, no NaN/Inf handling.
//  Normalise: negative acc -> negate, flip sign. Leading-one shift gives lz (0..31).
//    expn = acc_exp - lz + 17 - 127.
//    expn<=0 -> 0x00000000. Else {sign, expn[7:0], mant[30:8]}; truncate, no rounding.
//  wr_en and start outside IDLE are ignored. wr_en with start in IDLE: write is performed
//    and start is accepted; the new weight is visible to element 0.
//  Async reset mid-operation: immediate return to IDLE, out_valid drops, partial sums lost.
// TESTING
//  1 reset, no stimulus -> busy=0, d_ready=0, out_valid=0, out_data=0.
//  2 all lanes W[0..2]=0x3F80, len=3, no bias, d=0x3F80,0x4000,0x4040 -> every lane 0x40C00000.
//  3 lane0 W[0]=0x4000, bias=0xBF80, use_bias, len=1, d=0x3F00 -> lane0 0x00000000.
//  4 len=0, use_bias, bias=0x4040 -> 0x40400000; d_ready stays 0; out_valid 5 cycles after start.
//  5 d_valid gaps + out_ready low 6 cycles -> out_data stable, start/wr_en ignored until handshake.
//  6 reset pulse mid-RUN -> IDLE at once; rerun of test 2 gives 0x40C00000, weights kept.

Source files
------------

// File: rtl/tiny_dnn_mac_array.sv
// Multi-lane bfloat16 dot-product engine. A single feature stream is broadcast to
// LANES neurons. Each neuron has a private weight RAM, a fixed-point accumulator and
// an fp32 normaliser. A sequencer runs one start/len command at a time.
module tiny_dnn_mac_array #(
   parameter int LANES  = 4,
   parameter int F_SIZE = 1024,
   parameter int AW     = $clog2(F_SIZE)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [$clog2(LANES)-1:0] wr_lane,
   input  logic [AW-1:0]            wr_addr,
   input  logic [15:0]              wr_data,
   input  logic                     start,
   input  logic [AW-1:0]            len,
   input  logic                     use_bias,
   output logic                     busy,
   input  logic                     d_valid,
   output logic                     d_ready,
   input  logic [15:0]              d_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [32*LANES-1:0]      out_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_RUN, S_BIAS, S_DRAIN1, S_DRAIN2, S_NORM, S_OUT
   } state_t;

   // Accumulator: sign of the running sum, exponent of its LSB scale, signed mantissa.
   typedef struct packed {
      logic               sgn;
      logic [8:0]         ex;
      logic signed [31:0] mag;
   } acc_t;

   localparam logic [15:0]   BF16_ONE  = 16'h3F80;
   localparam logic [AW-1:0] BIAS_ADDR = AW'(F_SIZE - 1);

   // One multiply-accumulate step. The product always sets the new scale; the old
   // sum is shifted to it, and the step is dropped if the old sum cannot be aligned.
   function automatic acc_t fma_step(input acc_t a, input logic [15:0] w, input logic [15:0] d);
      logic [15:0]        wm;
      logic [15:0]        dm;
      logic [15:0]        frac;
      logic [8:0]         expm;
      logic signed [10:0] expd;
      logic               p_sign;
      logic signed [31:0] acc_al;
      logic signed [48:0] ext;
      logic signed [48:0] align;
      logic               fits;
      acc_t               r;
      wm     = {8'd0, 1'b1, w[6:0]};
      dm     = {8'd0, 1'b1, d[6:0]};
      frac   = wm * dm;
      expm   = {1'b0, w[14:7]} + {1'b0, d[14:7]};
      expd   = $signed({2'b00, expm}) - $signed({2'b00, a.ex}) + 11'sd16;
      p_sign = w[15] ^ d[15];
      acc_al = (p_sign != a.sgn) ? -a.mag : a.mag;
      ext    = {acc_al[31], acc_al, 16'h0000};
      if (expd >= 64) begin
         align = '0;
      end else begin
         align = ext >>> expd[5:0];
      end
      fits = (&align[48:30]) || !(|align[48:30]);
      r    = a;
      if (!expd[10] && fits) begin
         r.sgn = p_sign;
         r.ex  = expm;
         r.mag = {16'h0000, frac} + align[31:0];
      end
      return r;
   endfunction

   // Convert the accumulator to fp32 by truncation. A zero sum has no leading one
   // and is reported as +0 rather than through the exponent formula.
   function automatic logic [31:0] normalise(input acc_t a);
      logic               sgn;
      logic [31:0]        m;
      logic [4:0]         lz;
      logic signed [10:0] expn;
      sgn = a.sgn;
      m   = a.mag;
      if (a.mag[31]) begin
         m   = -a.mag;
         sgn = ~sgn;
      end
      lz = 5'd31;
      for (int i = 0; i < 32; i++) begin
         if (m[i]) lz = 5'(31 - i);
      end
      expn = $signed({2'b00, a.ex}) - $signed({6'd0, lz}) + 11'sd17 - 11'sd127;
      if (m == 32'd0 || expn <= 0) return 32'h0000_0000;
      return {sgn, expn[7:0], 23'((m << lz) >> 8)};
   endfunction

   state_t              state_q, state_d;
   logic [AW-1:0]       cnt_q, cnt_d;
   logic [AW-1:0]       len_q, len_d;
   logic                use_bias_q, use_bias_d;
   logic                vld_p0_q, vld_p0_d;
   logic [15:0]         d_p0_q, d_p0_d;
   logic [15:0]         w_p0_q [LANES];
   acc_t                acc_q [LANES];
   acc_t                acc_d [LANES];
   logic                out_valid_q, out_valid_d;
   logic [32*LANES-1:0] out_data_q, out_data_d;
   logic [15:0]         wram [LANES][F_SIZE];
   logic [AW-1:0]       rd_addr;
   logic                wr_we;

   // Sequencer next-state, feature stream handshake and per-lane accumulate/normalise.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      use_bias_d  = use_bias_q;
      vld_p0_d    = 1'b0;
      d_p0_d      = d_p0_q;
      rd_addr     = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      d_ready     = 1'b0;
      wr_we       = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         acc_d[i] = acc_q[i];
         if (vld_p0_q) acc_d[i] = fma_step(acc_q[i], w_p0_q[i], d_p0_q);
      end
      case (state_q)
         S_IDLE: begin
            wr_we = wr_en && (32'(wr_lane) < LANES);
            if (start) begin
               state_d    = S_RUN;
               cnt_d      = '0;
               len_d      = len;
               use_bias_d = use_bias;
               for (int i = 0; i < LANES; i++) acc_d[i] = '0;
            end
         end
         S_RUN: begin
            if (cnt_q == len_q) begin
               state_d = use_bias_q ? S_BIAS : S_DRAIN1;
            end else begin
               d_ready = 1'b1;
               if (d_valid) begin
                  cnt_d    = cnt_q + 1'b1;
                  vld_p0_d = 1'b1;
                  d_p0_d   = d_data;
               end
            end
         end
         S_BIAS: begin
            rd_addr  = BIAS_ADDR;
            vld_p0_d = 1'b1;
            d_p0_d   = BF16_ONE;
            state_d  = S_DRAIN1;
         end
         S_DRAIN1: state_d = S_DRAIN2;
         S_DRAIN2: state_d = S_NORM;
         S_NORM: begin
            out_valid_d = 1'b1;
            for (int i = 0; i < LANES; i++) out_data_d[32*i +: 32] = normalise(acc_q[i]);
            state_d = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control, accumulators and result register; cleared by asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         use_bias_q  <= 1'b0;
         vld_p0_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         use_bias_q  <= use_bias_d;
         vld_p0_q    <= vld_p0_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
      end
   end

   // ---- stage p0: registered weight read and feature capture ----
   always_ff @(posedge clk) begin
      d_p0_q <= d_p0_d;
      if (vld_p0_d) begin
         for (int i = 0; i < LANES; i++) w_p0_q[i] <= wram[i][rd_addr];
      end
   end

   // Weight RAM write port, only open while idle.
   always_ff @(posedge clk) begin
      if (wr_we) wram[wr_lane][wr_addr] <= wr_data;
   end

   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule
